// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty,
// standard or first-word-fall-through read, synchronous flush and sticky error flags.
module sync_fifo_flex #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 6,
   parameter int AFULL_THRESH  = 56,
   parameter int AEMPTY_THRESH = 8,
   parameter int FWFT          = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] data_out,
   input  logic                  flush,
   input  logic                  clr_err,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
   localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
   localparam logic [ADDR_WIDTH:0] ONE_C    = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH:0] ZERO_C   = (ADDR_WIDTH + 1)'(0);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [ADDR_WIDTH:0]   wptr_r;
   logic [ADDR_WIDTH:0]   rptr_r;
   logic [ADDR_WIDTH:0]   count_r;
   logic [ADDR_WIDTH:0]   wptr_next_s;
   logic [ADDR_WIDTH:0]   rptr_next_s;
   logic [ADDR_WIDTH:0]   count_next_s;
   logic                  wr_acc_s;
   logic                  rd_acc_s;
   logic                  full_r;
   logic                  empty_r;
   logic                  almost_full_r;
   logic                  almost_empty_r;
   logic                  overflow_r;
   logic                  underflow_r;
   logic [DATA_WIDTH-1:0] data_out_r;

   // Flush drops both requests, so a flushed cycle can never touch memory or error flags.
   assign wr_acc_s = wr_en & ~full_r & ~flush;
   assign rd_acc_s = rd_en & ~empty_r & ~flush;

   // Next pointer and occupancy values.
   always_comb begin
      wptr_next_s  = wptr_r;
      rptr_next_s  = rptr_r;
      count_next_s = count_r;
      if (flush) begin
         wptr_next_s  = ZERO_C;
         rptr_next_s  = ZERO_C;
         count_next_s = ZERO_C;
      end else begin
         if (wr_acc_s) begin
            wptr_next_s = wptr_r + ONE_C;
         end else begin
            wptr_next_s = wptr_r;
         end
         if (rd_acc_s) begin
            rptr_next_s = rptr_r + ONE_C;
         end else begin
            rptr_next_s = rptr_r;
         end
         case ({wr_acc_s, rd_acc_s})
            2'b10:   count_next_s = count_r + ONE_C;
            2'b01:   count_next_s = count_r - ONE_C;
            default: count_next_s = count_r;
         endcase
      end
   end

   // Pointer, count and status-flag registers; flags derive from the next count.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_r         <= ZERO_C;
         rptr_r         <= ZERO_C;
         count_r        <= ZERO_C;
         full_r         <= 1'b0;
         empty_r        <= 1'b1;
         almost_full_r  <= 1'b0;
         almost_empty_r <= 1'b1;
      end else begin
         wptr_r         <= wptr_next_s;
         rptr_r         <= rptr_next_s;
         count_r        <= count_next_s;
         full_r         <= (count_next_s == DEPTH_C);
         empty_r        <= (count_next_s == ZERO_C);
         almost_full_r  <= (count_next_s >= AFULL_C);
         almost_empty_r <= (count_next_s <= AEMPTY_C);
      end
   end

   // Sticky error flags; a fresh error beats clr_err in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (wr_en & full_r & ~flush) begin
            overflow_r <= 1'b1;
         end else if (clr_err) begin
            overflow_r <= 1'b0;
         end else begin
            overflow_r <= overflow_r;
         end
         if (rd_en & empty_r & ~flush) begin
            underflow_r <= 1'b1;
         end else if (clr_err) begin
            underflow_r <= 1'b0;
         end else begin
            underflow_r <= underflow_r;
         end
      end
   end

   // Storage array; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_acc_s & ~rst) begin
         mem_r[wptr_r[ADDR_WIDTH-1:0]] <= data_in;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         logic head_bypass_s;
         // The new head is being written this very edge when it sits at the write pointer.
         assign head_bypass_s = wr_acc_s & (rptr_next_s == wptr_r);

         // Output register tracks the head word for the next cycle, zero when empty.
         always_ff @(posedge clk) begin
            if (rst) begin
               data_out_r <= {DATA_WIDTH{1'b0}};
            end else if (count_next_s == ZERO_C) begin
               data_out_r <= {DATA_WIDTH{1'b0}};
            end else if (head_bypass_s) begin
               data_out_r <= data_in;
            end else begin
               data_out_r <= mem_r[rptr_next_s[ADDR_WIDTH-1:0]];
            end
         end
      end else begin : g_std
         // Registered read: word appears one cycle after an accepted read, held otherwise.
         always_ff @(posedge clk) begin
            if (rst) begin
               data_out_r <= {DATA_WIDTH{1'b0}};
            end else if (rd_acc_s) begin
               data_out_r <= mem_r[rptr_r[ADDR_WIDTH-1:0]];
            end else begin
               data_out_r <= data_out_r;
            end
         end
      end
   endgenerate

   assign data_out     = data_out_r;
   assign full         = full_r;
   assign empty        = empty_r;
   assign almost_full  = almost_full_r;
   assign almost_empty = almost_empty_r;
   assign count        = count_r;
   assign overflow     = overflow_r;
   assign underflow    = underflow_r;

endmodule
